// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for MIPS DIV/DIVU, result = {remainder, quotient}.
// Optional macro DIV_EARLY_EXIT_EN: finish at once when |dividend| < |divisor|.
module div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               signed_div,
   input  logic               annul,
   input  logic [WIDTH-1:0]   opdata1,
   input  logic [WIDTH-1:0]   opdata2,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] result
);

   typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

   state_t           state;
   state_t           next_state;
   logic [WIDTH-1:0] dividend_q;
   logic [WIDTH-1:0] divisor_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH:0]   rem_q;
   logic [CNT_W-1:0] counter;
   logic             dvd_neg;
   logic             dsr_neg;
   logic [WIDTH-1:0] mag1;
   logic [WIDTH-1:0] mag2;
   logic [WIDTH-1:0] quo_fix;
   logic [WIDTH-1:0] rem_fix;
   logic [WIDTH+1:0] partial;
   logic [WIDTH+1:0] diff;
   logic             div_zero;
   logic             cnt_last;
   logic             early;

   assign mag1     = (signed_div && opdata1[WIDTH-1]) ? (~opdata1 + 1'b1) : opdata1;
   assign mag2     = (signed_div && opdata2[WIDTH-1]) ? (~opdata2 + 1'b1) : opdata2;
   assign div_zero = (opdata2 == '0);
   assign cnt_last = (counter == CNT_W'(WIDTH - 1));

   // One extra guard bit so the sign of the trial subtraction is unambiguous.
   assign partial  = {rem_q, dividend_q[WIDTH-1]};
   assign diff     = partial - {2'b00, divisor_q};

   assign quo_fix  = (dvd_neg ^ dsr_neg) ? (~quo_q + 1'b1) : quo_q;
   assign rem_fix  = dvd_neg ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];

`ifdef DIV_EARLY_EXIT_EN
   assign early = (mag1 < mag2);
`else
   assign early = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= FREE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         FREE: begin
            if (start) begin
               if (div_zero)   next_state = BYZERO;
               else if (early) next_state = END;
               else            next_state = ON;
            end
         end
         BYZERO:  next_state = annul ? FREE : END;
         ON: begin
            if (annul)         next_state = FREE;
            else if (cnt_last) next_state = END;
         end
         END:     next_state = FREE;
         default: next_state = FREE;
      endcase
   end

   // Working registers; a zero divisor loads zeros so END writes a zero result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dividend_q <= '0;
         divisor_q  <= '0;
         quo_q      <= '0;
         rem_q      <= '0;
         counter    <= '0;
         dvd_neg    <= 1'b0;
         dsr_neg    <= 1'b0;
      end else begin
         case (state)
            FREE: begin
               if (start) begin
                  counter <= '0;
                  quo_q   <= '0;
                  if (div_zero) begin
                     dividend_q <= '0;
                     divisor_q  <= '0;
                     rem_q      <= '0;
                     dvd_neg    <= 1'b0;
                     dsr_neg    <= 1'b0;
                  end else begin
                     dividend_q <= mag1;
                     divisor_q  <= mag2;
                     rem_q      <= early ? {1'b0, mag1} : '0;
                     dvd_neg    <= signed_div & opdata1[WIDTH-1];
                     dsr_neg    <= signed_div & opdata2[WIDTH-1];
                  end
               end
            end
            ON: begin
               if (!annul) begin
                  counter    <= counter + 1'b1;
                  dividend_q <= {dividend_q[WIDTH-2:0], 1'b0};
                  if (diff[WIDTH+1]) begin
                     rem_q <= partial[WIDTH:0];
                     quo_q <= {quo_q[WIDTH-2:0], 1'b0};
                  end else begin
                     rem_q <= diff[WIDTH:0];
                     quo_q <= {quo_q[WIDTH-2:0], 1'b1};
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
      end else begin
         busy <= (next_state == ON) || (next_state == BYZERO);
         done <= (state == END);
         if (state == END) result <= {rem_fix, quo_fix};
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: table-driven check of div_unit results and latency, plus annul and async-reset sequences.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        signed_div;
   logic        annul;
   logic [31:0] opdata1;
   logic [31:0] opdata2;
   logic        busy;
   logic        done;
   logic [63:0] result;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        sd;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
   } vec_t;

   vec_t vecs[12];

   always #5 clk = ~clk;

   div_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .signed_div (signed_div),
      .annul      (annul),
      .opdata1    (opdata1),
      .opdata2    (opdata2),
      .busy       (busy),
      .done       (done),
      .result     (result)
   );

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   // Clocks required from the accepting edge to the edge that raises done.
   function automatic int expLatency(input logic sd, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_EXIT_EN
      logic [31:0] ma;
      logic [31:0] mb;
`endif
      if (b == 32'd0) return 2;
`ifdef DIV_EARLY_EXIT_EN
      ma = (sd && a[31]) ? (32'd0 - a) : a;
      mb = (sd && b[31]) ? (32'd0 - b) : b;
      if (ma < mb) return 1;
`else
      if (sd && a[31] && 1'b0) return 0;
`endif
      return 33;
   endfunction

   task automatic applyStimulus(input logic sd, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      signed_div = sd;
      opdata1    = a;
      opdata2    = b;
      start      = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic waitDone(output int lat);
      lat = -1;
      for (int n = 1; n <= 100; n++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = n;
            break;
         end
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          lat;
      int          explat;
      logic [63:0] last_res;
      logic        saw_done;

      vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
      vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF};
      vecs[2]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0};
      vecs[3]  = '{1'b0, 32'd5,          32'd0,          32'd0,          32'd0};
      vecs[4]  = '{1'b0, 32'd1000,       32'd10,         32'd100,        32'd0};
      vecs[5]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0};
      vecs[6]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1};
      vecs[7]  = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3};
      vecs[8]  = '{1'b1, 32'hFFFFFFFD,   32'd10,         32'd0,          32'hFFFFFFFD};
      vecs[9]  = '{1'b1, 32'd0,          32'd5,          32'd0,          32'd0};
      vecs[10] = '{1'b1, 32'hFFFFFFFF,   32'd0,          32'd0,          32'd0};
      vecs[11] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFE,   32'd1,          32'd1};

      rst        = 1'b1;
      start      = 1'b0;
      signed_div = 1'b0;
      annul      = 1'b0;
      opdata1    = '0;
      opdata2    = '0;
      #12;
      checkOutput("reset busy", {63'd0, busy}, 64'd0);
      checkOutput("reset done", {63'd0, done}, 64'd0);
      checkOutput("reset result", result, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 12; i++) begin
         explat = expLatency(vecs[i].sd, vecs[i].a, vecs[i].b);
         applyStimulus(vecs[i].sd, vecs[i].a, vecs[i].b);
         checkOutput($sformatf("v%0d busy after accept", i), {63'd0, busy}, {63'd0, explat != 1});
         waitDone(lat);
         checkOutput($sformatf("v%0d latency", i), 64'(lat), 64'(explat));
         checkOutput($sformatf("v%0d result", i), result, {vecs[i].r, vecs[i].q});
         @(posedge clk);
         #1;
         checkOutput($sformatf("v%0d done one cycle", i), {63'd0, done}, 64'd0);
         checkOutput($sformatf("v%0d busy after done", i), {63'd0, busy}, 64'd0);
      end
      last_res = {vecs[11].r, vecs[11].q};

      // Annul on edge 10 of 100/7: no done, result kept, then a fresh division.
      applyStimulus(1'b0, 32'd100, 32'd7);
      repeat (9) @(posedge clk);
      #1;
      annul = 1'b1;
      @(posedge clk);
      #1;
      annul = 1'b0;
      checkOutput("annul busy drops", {63'd0, busy}, 64'd0);
      saw_done = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done) saw_done = 1'b1;
      end
      checkOutput("annul no done", {63'd0, saw_done}, 64'd0);
      checkOutput("annul result kept", result, last_res);
      applyStimulus(1'b0, 32'd1000, 32'd10);
      waitDone(lat);
      checkOutput("post-annul latency", 64'(lat), 64'd33);
      checkOutput("post-annul result", result, {32'd0, 32'd100});

      // Asynchronous reset in mid-division.
      applyStimulus(1'b0, 32'd100, 32'd7);
      repeat (15) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      checkOutput("async reset busy", {63'd0, busy}, 64'd0);
      checkOutput("async reset done", {63'd0, done}, 64'd0);
      checkOutput("async reset result", result, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(1'b0, 32'd9, 32'd4);
      waitDone(lat);
      checkOutput("post-reset latency", 64'(lat), 64'd33);
      checkOutput("post-reset result", result, {32'd1, 32'd2});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
